// File: rtl/pwm_guard_pkg.sv
// Shared definitions for the PWM fault guard: state encoding, register map, safe levels.
package pwm_guard_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_COOLDOWN = 2'd3
    } guard_state_e;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_CLEAR    = 1;
    localparam int CTRL_OCP_MASK = 2;

    localparam int STAT_ARMED    = 0;
    localparam int STAT_TRIPPED  = 1;
    localparam int STAT_COOLDOWN = 2;
    localparam int STAT_CAUSE_OCP  = 3;
    localparam int STAT_CAUSE_ST_A = 4;
    localparam int STAT_CAUSE_ST_B = 5;
    localparam int STAT_OCP_MASK   = 6;
    localparam int STAT_OCP_LEVEL  = 7;

    localparam logic ADDR_CTRL    = 1'b0;
    localparam logic ADDR_TRIPCNT = 1'b1;

    localparam logic SAFE_PMOS = 1'b1;
    localparam logic SAFE_NMOS = 1'b0;

endpackage

// File: rtl/pwm_guard_debounce.sv
// Optional 2-FF synchronizer feeding a consecutive-high sample counter.
// trip_o is asserted while the current sample completes a run of THRESH highs.
module pwm_guard_debounce #(
    parameter int THRESH  = 4,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    input  logic hold_i,
    output logic level_o,
    output logic trip_o
);

    localparam logic [3:0] LIMIT = 4'(THRESH - 1);

    logic [3:0] cnt_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) sync_q <= '0;
                else       sync_q <= {sync_q[0], din_i};
            end
            assign level_o = sync_q[1];
        end else begin : g_bypass
            assign level_o = din_i;
        end
    endgenerate

    // cnt_q holds the number of earlier consecutive highs, saturating at LIMIT
    always_ff @(posedge clk_i) begin
        if (rst_i || hold_i || !level_o) cnt_q <= '0;
        else if (cnt_q != LIMIT)         cnt_q <= cnt_q + 4'd1;
    end

    assign trip_o = level_o & ~hold_i & (cnt_q == LIMIT);

endmodule

// File: rtl/pwm_fault_guard.sv
// Gate-drive protection between the PWM wrapper and the bridge pins.
// Define PWM_FAULT_GUARD_TRIPCNT_EN to add the saturating trip counter at addr 1.
//
// state    | meaning
// DISARMED | outputs safe, waiting for ARM
// ARMED    | gate inputs passed straight through
// TRIPPED  | outputs safe, causes latched, fault_o high
// COOLDOWN | outputs safe, counting down before returning to DISARMED
module pwm_fault_guard #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int ST_CYC       = 2,
    parameter int COOLDOWN_CYC = 200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       write_en_i,
    input  logic       addr_lsb_i,
    input  logic [7:0] data_in_i,
    output logic [7:0] rd_data_o,
    input  logic       pmos1_i,
    input  logic       nmos2_i,
    input  logic       pmos2_i,
    input  logic       nmos1_i,
    input  logic       ocp_i,
    output logic       pmos1_o,
    output logic       nmos2_o,
    output logic       pmos2_o,
    output logic       nmos1_o,
    output logic       fault_o
);
    import pwm_guard_pkg::*;

    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYC);

    guard_state_e state_q;
    logic         cause_ocp_q, cause_st_a_q, cause_st_b_q;
    logic         mask_q, fault_q;
    logic [7:0]   cool_cnt_q;
    logic [7:0]   status, tripcnt;
    logic         ctrl_wr, cnt_wr, trip_take;
    logic         ocp_level, ocp_trip, st_a_trip, st_b_trip, trip_any;
    logic         st_a_level_unused, st_b_level_unused;
    logic [4:0]   data_hi_unused;

    assign data_hi_unused = data_in_i[7:3];
    assign ctrl_wr   = cs_i & write_en_i & (addr_lsb_i == ADDR_CTRL);
    assign cnt_wr    = cs_i & write_en_i & (addr_lsb_i == ADDR_TRIPCNT);

    pwm_guard_debounce #(.THRESH(DEBOUNCE_CYC), .SYNC_EN(1'b1)) u_ocp (
        .clk_i(clk_i), .rst_i(rst_i), .din_i(ocp_i), .hold_i(mask_q),
        .level_o(ocp_level), .trip_o(ocp_trip));

    pwm_guard_debounce #(.THRESH(ST_CYC), .SYNC_EN(1'b0)) u_st_a (
        .clk_i(clk_i), .rst_i(rst_i), .din_i(~pmos1_i & nmos2_i), .hold_i(1'b0),
        .level_o(st_a_level_unused), .trip_o(st_a_trip));

    pwm_guard_debounce #(.THRESH(ST_CYC), .SYNC_EN(1'b0)) u_st_b (
        .clk_i(clk_i), .rst_i(rst_i), .din_i(~pmos2_i & nmos1_i), .hold_i(1'b0),
        .level_o(st_b_level_unused), .trip_o(st_b_trip));

    assign trip_any  = ocp_trip | st_a_trip | st_b_trip;
    assign trip_take = (state_q == ST_ARMED) & trip_any;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_DISARMED;
            cause_ocp_q  <= 1'b0;
            cause_st_a_q <= 1'b0;
            cause_st_b_q <= 1'b0;
            mask_q       <= 1'b0;
            fault_q      <= 1'b0;
            cool_cnt_q   <= '0;
        end else begin
            if (ctrl_wr) mask_q <= data_in_i[CTRL_OCP_MASK];
            case (state_q)
                ST_DISARMED: if (ctrl_wr && data_in_i[CTRL_ARM]) state_q <= ST_ARMED;
                ST_ARMED: begin
                    // a trip wins over a disarm write landing in the same cycle
                    if (trip_any) begin
                        state_q      <= ST_TRIPPED;
                        fault_q      <= 1'b1;
                        cause_ocp_q  <= ocp_trip;
                        cause_st_a_q <= st_a_trip;
                        cause_st_b_q <= st_b_trip;
                    end else if (ctrl_wr && !data_in_i[CTRL_ARM]) begin
                        state_q <= ST_DISARMED;
                    end
                end
                ST_TRIPPED: if (ctrl_wr && data_in_i[CTRL_CLEAR]) begin
                    state_q      <= ST_COOLDOWN;
                    fault_q      <= 1'b0;
                    cause_ocp_q  <= 1'b0;
                    cause_st_a_q <= 1'b0;
                    cause_st_b_q <= 1'b0;
                    cool_cnt_q   <= COOL_LOAD;
                end
                ST_COOLDOWN: begin
                    cool_cnt_q <= cool_cnt_q - 8'd1;
                    if (cool_cnt_q == 8'd1) state_q <= ST_DISARMED;
                end
                default: state_q <= ST_DISARMED;
            endcase
        end
    end

`ifdef PWM_FAULT_GUARD_TRIPCNT_EN
    logic [7:0] tripcnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_wr)                     tripcnt_q <= '0;
        else if (trip_take && tripcnt_q != 8'hFF) tripcnt_q <= tripcnt_q + 8'd1;
    end
    assign tripcnt = tripcnt_q;
`else
    logic cnt_unused;
    assign cnt_unused = cnt_wr & trip_take;
    assign tripcnt    = 8'h00;
`endif

    always_comb begin
        status                  = '0;
        status[STAT_ARMED]      = (state_q == ST_ARMED);
        status[STAT_TRIPPED]    = (state_q == ST_TRIPPED);
        status[STAT_COOLDOWN]   = (state_q == ST_COOLDOWN);
        status[STAT_CAUSE_OCP]  = cause_ocp_q;
        status[STAT_CAUSE_ST_A] = cause_st_a_q;
        status[STAT_CAUSE_ST_B] = cause_st_b_q;
        status[STAT_OCP_MASK]   = mask_q;
        status[STAT_OCP_LEVEL]  = ocp_level;
        rd_data_o = (addr_lsb_i == ADDR_TRIPCNT) ? tripcnt : status;
    end

    always_comb begin
        pmos1_o = SAFE_PMOS;
        nmos2_o = SAFE_NMOS;
        pmos2_o = SAFE_PMOS;
        nmos1_o = SAFE_NMOS;
        if (state_q == ST_ARMED) begin
            pmos1_o = pmos1_i;
            nmos2_o = nmos2_i;
            pmos2_o = pmos2_i;
            nmos1_o = nmos1_i;
        end
    end

    assign fault_o = fault_q;

endmodule

// File: tb/tb_pwm_fault_guard.sv
// Scoreboard bench for pwm_fault_guard: expectations queued with stimulus, popped on sampling.
module tb_pwm_fault_guard;

    logic       clk_i = 1'b0;
    logic       rst_i, cs_i, write_en_i, addr_lsb_i, ocp_i;
    logic [7:0] data_in_i, rd_data_o;
    logic       pmos1_o, nmos2_o, pmos2_o, nmos1_o, fault_o;
    logic [3:0] gin;
    logic [3:0] gout;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_trips = 0;
    int   n;

    pwm_fault_guard dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .write_en_i(write_en_i),
        .addr_lsb_i(addr_lsb_i), .data_in_i(data_in_i), .rd_data_o(rd_data_o),
        .pmos1_i(gin[3]), .nmos2_i(gin[2]), .pmos2_i(gin[1]), .nmos1_i(gin[0]),
        .ocp_i(ocp_i),
        .pmos1_o(pmos1_o), .nmos2_o(nmos2_o), .pmos2_o(pmos2_o), .nmos1_o(nmos1_o),
        .fault_o(fault_o));

    assign gout = {pmos1_o, nmos2_o, pmos2_o, nmos1_o};

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached=1 required=0");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.tag = "sb_empty";
            e.val = ~obs;
        end
        check(e.tag, obs, e.val);
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(posedge clk_i);
        #1;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        cs_i = 1'b1; write_en_i = 1'b1; addr_lsb_i = a; data_in_i = d;
        step(1);
        cs_i = 1'b0; write_en_i = 1'b0; addr_lsb_i = 1'b0; data_in_i = 8'h00;
    endtask

    task automatic sample_reg(input logic a);
        addr_lsb_i = a;
        #1;
        pop_check({24'h0, rd_data_o});
        addr_lsb_i = 1'b0;
    endtask

    task automatic sample_gates();
        #1;
        pop_check({28'h0, gout});
    endtask

    task automatic sample_fault();
        #1;
        pop_check({31'h0, fault_o});
    endtask

    task automatic wait_cooldown_exit();
        int k;
        k = 0;
        addr_lsb_i = 1'b0;
        #1;
        while (rd_data_o[2] && k < 400) begin
            step(1);
            k++;
        end
        push_exp("cool_exit", 0);
        pop_check({31'h0, rd_data_o[2]});
    endtask

    task automatic clear_and_rearm();
        push_exp("clr_status", 8'h04);
        cpu_write(1'b0, 8'h02);
        sample_reg(1'b0);
        wait_cooldown_exit();
        push_exp("rearm_status", 8'h01);
        cpu_write(1'b0, 8'h01);
        sample_reg(1'b0);
    endtask

    initial begin
        rst_i = 1'b1; cs_i = 1'b0; write_en_i = 1'b0; addr_lsb_i = 1'b0;
        data_in_i = 8'h00; gin = 4'b0011; ocp_i = 1'b0;
        step(3);
        rst_i = 1'b0;

        push_exp("rst_status", 8'h00); sample_reg(1'b0);
        push_exp("rst_gates", 4'b1010); sample_gates();
        push_exp("rst_fault", 0);       sample_fault();

        push_exp("arm_status", 8'h01);
        cpu_write(1'b0, 8'h01);
        sample_reg(1'b0);
        push_exp("pass_gates_a", 4'b0011); sample_gates();
        gin = 4'b1100;
        push_exp("pass_gates_b", 4'b1100); sample_gates();
        push_exp("arm_fault", 0);          sample_fault();

        // short overcurrent glitches must not trip
        repeat (3) begin
            ocp_i = 1'b1; step(3);
            ocp_i = 1'b0; step(3);
        end
        push_exp("ocp_glitch_status", 8'h01); sample_reg(1'b0);

        push_exp("ocp_latency", 6);
        ocp_i = 1'b1;
        n = 0;
        while (!fault_o && n < 20) begin
            step(1);
            n++;
        end
        pop_check(n);
        exp_trips++;
        push_exp("ocp_trip_status", 8'h8A); sample_reg(1'b0);
        push_exp("ocp_trip_gates", 4'b1010); sample_gates();
        push_exp("ocp_trip_fault", 1);       sample_fault();
        ocp_i = 1'b0;
        step(3);
        push_exp("ocp_hold_status", 8'h0A); sample_reg(1'b0);

        push_exp("cool_status", 8'h04);
        cpu_write(1'b0, 8'h02);
        sample_reg(1'b0);
        push_exp("cool_fault", 0); sample_fault();
        push_exp("cool_cycles", 200);
        n = 1;
        cpu_write(1'b0, 8'h01);
        addr_lsb_i = 1'b0;
        #1;
        while (rd_data_o[2] && n < 400) begin
            n++;
            step(1);
        end
        pop_check(n);
        push_exp("arm_ignored", 8'h00); sample_reg(1'b0);
        push_exp("rearm_status", 8'h01);
        cpu_write(1'b0, 8'h01);
        sample_reg(1'b0);

        gin = 4'b0110;
        push_exp("st_pass_gates", 4'b0110); sample_gates();
        step(1);
        gin = 4'b1100;
        step(2);
        push_exp("st_1cyc_status", 8'h01); sample_reg(1'b0);

        gin = 4'b0110;
        step(2);
        gin = 4'b1100;
        exp_trips++;
        push_exp("st_a_status", 8'h12); sample_reg(1'b0);
        push_exp("st_a_gates", 4'b1010); sample_gates();
        clear_and_rearm();

        gin = 4'b0101;
        step(2);
        gin = 4'b1100;
        exp_trips++;
        push_exp("st_ab_status", 8'h32); sample_reg(1'b0);
        clear_and_rearm();

        // disarm write in the same cycle as a trip
        gin = 4'b0110;
        step(1);
        push_exp("trip_vs_disarm", 8'h12);
        cpu_write(1'b0, 8'h00);
        gin = 4'b1100;
        exp_trips++;
        sample_reg(1'b0);
        clear_and_rearm();

        push_exp("mask_status", 8'h41);
        cpu_write(1'b0, 8'h05);
        sample_reg(1'b0);
        ocp_i = 1'b1;
        step(50);
        push_exp("mask_ocp_high", 8'hC1); sample_reg(1'b0);
        ocp_i = 1'b0;
        step(3);
        push_exp("mask_ocp_low", 8'h41); sample_reg(1'b0);
        push_exp("unmask_status", 8'h01);
        cpu_write(1'b0, 8'h01);
        sample_reg(1'b0);

`ifdef PWM_FAULT_GUARD_TRIPCNT_EN
        push_exp("tripcnt", exp_trips);
`else
        push_exp("tripcnt", 0);
`endif
        sample_reg(1'b1);
        cpu_write(1'b1, 8'hFF);
        push_exp("tripcnt_zeroed", 0);          sample_reg(1'b1);
        push_exp("status_after_cnt_wr", 8'h01); sample_reg(1'b0);

        push_exp("disarm_status", 8'h00);
        cpu_write(1'b0, 8'h00);
        sample_reg(1'b0);
        push_exp("disarm_gates", 4'b1010); sample_gates();

        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
